frame_reader: RTL and testbench
===============================

Name: frame_reader

Overview:
- Downstream companion of the pixel-capture write stage.
- Once a frame has been written to DDR, this block replays it from memory through the MIG read request/ack port into an output FIFO for the host pipe.
- It issues fixed-size burst reads, limits the number of outstanding reads by credit, and pulses frame_read_done when the last burst's data has been delivered.
- Lives entirely in the memory clock domain.

Parameters:
- LEN_W, 20, width of frame_len (bursts per frame)
- ADDRESS_INCREMENT, 8, mem_rd_addr step per accepted burst (UI word address, BL8)
- MAX_OUTSTANDING, 8, maximum accepted-but-unreturned bursts; power of two, ≥2

Ports:
- clk  in  1  memory UI clock
- mem_reset  in  1  async active-high reset
- start  in  1  one-cycle pulse; begin reading a frame
- start_addr  in  30  byte address of frame; [29:1] used as word address
- frame_len  in  LEN_W  number of 256-bit bursts to read
- busy  out  1  high from accepted start until done
- frame_read_done  out  1  one-cycle pulse at completion
- mem_rd_req  out  1  read request, held until ack
- mem_rd_addr  out  29  read word address
- mem_rd_ack  in  1  MIG accepted current request
- mem_rd_data_valid  in  1  one 256-bit beat returned
- mem_rd_data  in  256  returned data
- ofifo_wr_en  out  1  output FIFO write strobe
- ofifo_din  out  256  output FIFO data
- ofifo_prog_full  in  1  FIFO cannot absorb MAX_OUTSTANDING more beats
- overflow  out  1  sticky: data beat arrived with zero outstanding

Behaviour:
Clocking and reset:
- Clock clk. Reset mem_reset, asynchronous, active-high.
- All outputs are 0 on reset and the state is S_IDLE.
- Reset mid-frame abandons the frame; no done pulse is issued.

State machine S_IDLE, S_ISSUE, S_ACK, S_DRAIN, S_DONE:
- S_IDLE:
  - On start, latch start_addr[29:1] into mem_rd_addr and frame_len into remaining; set busy.
  - If frame_len==0, go to S_DONE; otherwise go to S_ISSUE.
  - start while busy is ignored.
- S_ISSUE:
  - If remaining==0, go to S_DRAIN.
  - Otherwise, if outstanding<MAX_OUTSTANDING, !ofifo_prog_full and !mem_rd_ack: assert mem_rd_req and go to S_ACK.
- S_ACK:
  - mem_rd_req stays high until mem_rd_ack.
  - On ack: mem_rd_addr += ADDRESS_INCREMENT, remaining−1, outstanding+1, deassert req, go to S_ISSUE.
- S_DRAIN: when outstanding==0, go to S_DONE.
- S_DONE:
  - frame_read_done=1 for exactly one cycle; busy cleared in the same cycle.
  - Go to S_IDLE.

Datapath and counters:
- Data path latency is 1 cycle, registered: ofifo_wr_en <= mem_rd_data_valid and ofifo_din <= mem_rd_data, in every state. Beats are never dropped.
- outstanding counter (clog2(MAX_OUTSTANDING)+1 bits) updates per cycle:
  - +1 on ack, −1 on data_valid, unchanged if both occur.
  - A data_valid with outstanding==0 sets overflow (sticky until reset) and the counter does not underflow.
- Address arithmetic is modulo 2^29; wrap is permitted.
- The beat count delivered per frame equals frame_len.

Optional Feature:
- FRAME_READER_TIMEOUT_EN, when defined:
  - A 24-bit watchdog counts cycles in S_ACK/S_DRAIN with no ack and no data_valid. Any ack or data_valid clears it.
  - At 0xFFFFFF: pulse timeout (additional 1-bit output port), force outstanding=0, go to S_DONE (done pulses normally).
- When undefined: no timeout port, no counter, and the block waits indefinitely.

Decomposition:
- Shared package camera_mem_pkg: ADDRESS_INCREMENT, BURST_BYTES=32, the MIG UI address width (29), and the state encoding.
  - The capture write path uses the same package.
- One natural sub-module: frame_reader_credit, the outstanding counter with underflow/overflow flag and a can_issue output.

Test Plan:
1. start_addr=0x1000, frame_len=4, ack after 2 cycles, data 3 cycles after each ack:
   - mem_rd_addr sequence 0x800, 0x808, 0x810, 0x818.
   - 4 ofifo_wr_en beats with matching data.
   - Single done pulse; busy low after.
2. frame_len=0:
   - No mem_rd_req.
   - frame_read_done asserted 2 cycles after start.
3. MAX_OUTSTANDING=8, frame_len=20, data withheld:
   - Exactly 8 acks occur, then req stays low.
   - Release data; all 20 beats arrive, then done.
4. ofifo_prog_full held high after 3 bursts:
   - No further req while high.
   - Deassert; remaining bursts complete.
   - Beat count 20, no overflow.
5. Ack and data_valid in the same cycle repeatedly: outstanding stays constant; final count correct. Separately, a spurious data_valid in S_IDLE sets overflow=1.
6. mem_reset asserted mid-frame (after 5 of 10 bursts):
   - All outputs 0 immediately, with no done pulse.
   - A new start then reads a fresh 10 bursts from its own address.

Source files
------------

// File: rtl/camera_mem_pkg.sv
// camera_mem_pkg: constants and the read-FSM state encoding shared by the
// camera memory blocks (the pixel-capture write path and frame_reader).
//   MIG_ADDR_W        MIG UI word-address width
//   BURST_BYTES       bytes per BL8 burst of the 256-bit UI
//   ADDRESS_INCREMENT word-address step per burst
//   rd_state_t        frame_reader state encoding
package camera_mem_pkg;
    localparam int MIG_ADDR_W        = 29;
    localparam int BURST_BYTES       = 32;
    localparam int DATA_W            = BURST_BYTES * 8;
    localparam int ADDRESS_INCREMENT = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_ACK   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } rd_state_t;
endpackage

// File: rtl/frame_reader_if.sv
// frame_reader_if: MIG read request/ack/data port plus the output FIFO
// write port used by the frame reader.
//   master : the reader (drives req/addr and FIFO writes)
//   slave  : MIG + FIFO side (drives ack, returned data, prog_full)
interface frame_reader_if;
    import camera_mem_pkg::*;

    logic                  mem_rd_req;
    logic [MIG_ADDR_W-1:0] mem_rd_addr;
    logic                  mem_rd_ack;
    logic                  mem_rd_data_valid;
    logic [DATA_W-1:0]     mem_rd_data;
    logic                  ofifo_wr_en;
    logic [DATA_W-1:0]     ofifo_din;
    logic                  ofifo_prog_full;

    modport master (
        output mem_rd_req, mem_rd_addr, ofifo_wr_en, ofifo_din,
        input  mem_rd_ack, mem_rd_data_valid, mem_rd_data, ofifo_prog_full
    );

    modport slave (
        input  mem_rd_req, mem_rd_addr, ofifo_wr_en, ofifo_din,
        output mem_rd_ack, mem_rd_data_valid, mem_rd_data, ofifo_prog_full
    );
endinterface

// File: rtl/frame_reader_credit.sv
// frame_reader_credit: count of accepted-but-unreturned bursts.
//   clk, mem_reset  clock, async active-high reset
//   inc             a burst request was accepted
//   dec             a data beat returned
//   clear           drop all credit (watchdog recovery)
//   count           current outstanding bursts
//   can_issue       room for one more burst
//   overflow        sticky: a beat returned with nothing outstanding
module frame_reader_credit #(
    parameter  int MAX_OUTSTANDING = 8,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic             clk,
    input  logic             mem_reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             can_issue,
    output logic             overflow
);
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        // A beat with zero credit is flagged; the counter is held rather
        // than wrapped so the reader can still finish the frame.
        if (dec && count_q == '0)
            overflow_d = 1'b1;
        if (clear)
            count_d = '0;
        else if (inc && !dec)
            count_d = count_q + CNT_W'(1);
        else if (dec && !inc && count_q != '0)
            count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge mem_reset) begin
        if (mem_reset) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign count     = count_q;
    assign can_issue = count_q < CNT_W'(MAX_OUTSTANDING);
    assign overflow  = overflow_q;
endmodule

// File: rtl/frame_reader.sv
// frame_reader: replays a frame from DDR through the MIG read port into the
// host output FIFO using fixed-size burst reads with credit-limited
// outstanding requests.
//   clk, mem_reset      memory UI clock, async active-high reset
//   start               one-cycle pulse; begin a frame (ignored while busy)
//   start_addr          frame byte address; [29:1] is the word address
//   frame_len           bursts to read
//   busy                high from accepted start until done
//   frame_read_done     one-cycle pulse after the last beat
//   overflow            sticky: a beat arrived with zero outstanding
//   timeout             watchdog pulse (only with FRAME_READER_TIMEOUT_EN)
//   bus                 MIG read + output FIFO port (master side)
// Build option: define FRAME_READER_TIMEOUT_EN to add a 24-bit stall
// watchdog that abandons the wait and finishes the frame.
module frame_reader #(
    parameter int LEN_W             = 20,
    parameter int ADDRESS_INCREMENT = camera_mem_pkg::ADDRESS_INCREMENT,
    parameter int MAX_OUTSTANDING   = 8
) (
    input  logic             clk,
    input  logic             mem_reset,
    input  logic             start,
    input  logic [29:0]      start_addr,
    input  logic [LEN_W-1:0] frame_len,
    output logic             busy,
    output logic             frame_read_done,
    output logic             overflow,
`ifdef FRAME_READER_TIMEOUT_EN
    output logic             timeout,
`endif
    frame_reader_if.master   bus
);
    import camera_mem_pkg::*;

    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    rd_state_t             state_q, state_d;
    logic [MIG_ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]      remaining_q, remaining_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  req_q, req_d;
    logic                  wr_en_q, wr_en_d;
    logic [DATA_W-1:0]     din_q, din_d;

    logic [CNT_W-1:0]      outstanding;
    logic                  can_issue;
    logic                  ack_taken;
    logic                  issue_ok;
    logic                  credit_clear;
    logic                  wd_expired;

    // Byte address bit 0 has no meaning on the word-addressed UI.
    logic unused_addr_lsb;
    assign unused_addr_lsb = start_addr[0];

    assign ack_taken = (state_q == S_ACK) && bus.mem_rd_ack;
    // A fresh request is not raised while ack is still high, so a stale
    // ack can never be taken for the new request.
    assign issue_ok  = (remaining_q != '0) && can_issue &&
                       !bus.ofifo_prog_full && !bus.mem_rd_ack;

`ifdef FRAME_READER_TIMEOUT_EN
    logic [23:0] wd_q, wd_d;
    logic        timeout_q, timeout_d;
    logic        wd_state;

    assign wd_state   = (state_q == S_ACK) || (state_q == S_DRAIN);
    assign wd_expired = wd_state && (wd_q == 24'hFF_FFFF);

    always_comb begin
        wd_d      = '0;
        timeout_d = wd_expired;
        if (wd_state && !bus.mem_rd_ack && !bus.mem_rd_data_valid && !wd_expired)
            wd_d = wd_q + 24'd1;
    end

    assign timeout = timeout_q;
`else
    assign wd_expired = 1'b0;
`endif

    assign credit_clear = wd_expired;

    frame_reader_credit #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_credit (
        .clk       (clk),
        .mem_reset (mem_reset),
        .inc       (ack_taken),
        .dec       (bus.mem_rd_data_valid),
        .clear     (credit_clear),
        .count     (outstanding),
        .can_issue (can_issue),
        .overflow  (overflow)
    );

    // State register (plus all datapath flops)
    always_ff @(posedge clk or posedge mem_reset) begin
        if (mem_reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            req_q       <= 1'b0;
            wr_en_q     <= 1'b0;
            din_q       <= '0;
`ifdef FRAME_READER_TIMEOUT_EN
            wd_q        <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            req_q       <= req_d;
            wr_en_q     <= wr_en_d;
            din_q       <= din_d;
`ifdef FRAME_READER_TIMEOUT_EN
            wd_q        <= wd_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (frame_len == '0) ? S_DONE : S_ISSUE;
            S_ISSUE: begin
                if (remaining_q == '0) state_d = S_DRAIN;
                else if (issue_ok)     state_d = S_ACK;
            end
            S_ACK:   if (ack_taken) state_d = S_ISSUE;
            S_DRAIN: if (outstanding == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (wd_expired) state_d = S_DONE;
    end

    // Outputs and datapath
    always_comb begin
        addr_d      = addr_q;
        remaining_d = remaining_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        req_d       = 1'b0;
        // Returned beats are forwarded in every state, never dropped.
        wr_en_d     = bus.mem_rd_data_valid;
        din_d       = bus.mem_rd_data;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d      = start_addr[29:1];
                    remaining_d = frame_len;
                    busy_d      = 1'b1;
                end
            end
            S_ISSUE: req_d = issue_ok;
            S_ACK: begin
                if (ack_taken) begin
                    addr_d      = addr_q + MIG_ADDR_W'(ADDRESS_INCREMENT);
                    remaining_d = remaining_q - LEN_W'(1);
                end else begin
                    req_d = 1'b1;
                end
            end
            S_DONE: begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: ;
        endcase
        if (wd_expired) req_d = 1'b0;
    end

    assign busy            = busy_q;
    assign frame_read_done = done_q;
    assign bus.mem_rd_req  = req_q;
    assign bus.mem_rd_addr = addr_q;
    assign bus.ofifo_wr_en = wr_en_q;
    assign bus.ofifo_din   = din_q;
endmodule

// File: tb/tb_frame_reader.sv
// tb_frame_reader: MIG/FIFO responder with a data scoreboard, a table of
// frame vectors, and hand-written sequences for zero-length frames, credit
// exhaustion, FIFO back-pressure, spurious beats and mid-frame reset.
module tb_frame_reader;
    import camera_mem_pkg::*;

    localparam int LEN_W = 20;

    logic             clk = 1'b0;
    logic             mem_reset = 1'b1;
    logic             start = 1'b0;
    logic [29:0]      start_addr = '0;
    logic [LEN_W-1:0] frame_len = '0;
    logic             busy, frame_read_done, overflow;
`ifdef FRAME_READER_TIMEOUT_EN
    logic             timeout;
`endif

    frame_reader_if bus();

    frame_reader #(.LEN_W(LEN_W), .ADDRESS_INCREMENT(8), .MAX_OUTSTANDING(8)) dut (
        .clk             (clk),
        .mem_reset       (mem_reset),
        .start           (start),
        .start_addr      (start_addr),
        .frame_len       (frame_len),
        .busy            (busy),
        .frame_read_done (frame_read_done),
        .overflow        (overflow),
`ifdef FRAME_READER_TIMEOUT_EN
        .timeout         (timeout),
`endif
        .bus             (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Responder / monitor state
    typedef struct { int due; logic [255:0] data; } ret_t;
    ret_t         rq[$];
    logic [255:0] sb[$];
    logic [28:0]  ack_addr[$];
    int  ack_dly = 1, data_dly = 1, pf_after = -1;
    bit  hold = 0, spur = 0;
    int  cyc = 0, req_cnt = 0;
    int  ack_cnt = 0, beat_cnt = 0, done_cnt = 0, req_hi = 0, max_out = 0;

    initial begin
        ret_t         r;
        logic [255:0] e;
        bus.mem_rd_ack        = 1'b0;
        bus.mem_rd_data_valid = 1'b0;
        bus.mem_rd_data       = '0;
        bus.ofifo_prog_full   = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            // monitor
            if (bus.ofifo_wr_en) begin
                beat_cnt++;
                if (sb.size() == 0) begin
                    n_assert++; n_fail++;
                    $display("FAIL beat_unexpected: got data %0h, expected no beat", bus.ofifo_din);
                end else begin
                    e = sb.pop_front();
                    check("beat_data", bus.ofifo_din, e);
                end
            end
            if (frame_read_done) done_cnt++;
            if (bus.mem_rd_req) req_hi++;
            if (int'(dut.u_credit.count_q) > max_out) max_out = int'(dut.u_credit.count_q);
            // ack channel
            bus.mem_rd_ack = 1'b0;
            if (bus.mem_rd_req && !mem_reset) begin
                req_cnt++;
                if (req_cnt >= ack_dly) begin
                    bus.mem_rd_ack = 1'b1;
                    req_cnt = 0;
                    ack_cnt++;
                    ack_addr.push_back(bus.mem_rd_addr);
                    r.due  = cyc + data_dly;
                    r.data = rnd256();
                    rq.push_back(r);
                    if (ack_cnt == pf_after) bus.ofifo_prog_full = 1'b1;
                end
            end
            // data channel
            bus.mem_rd_data_valid = 1'b0;
            if (spur) begin
                spur = 0;
                bus.mem_rd_data_valid = 1'b1;
                bus.mem_rd_data = rnd256();
                sb.push_back(bus.mem_rd_data);
            end else if (!hold && rq.size() > 0 && rq[0].due <= cyc) begin
                r = rq.pop_front();
                bus.mem_rd_data_valid = 1'b1;
                bus.mem_rd_data = r.data;
                sb.push_back(r.data);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic clear_counts();
        ack_cnt = 0; beat_cnt = 0; done_cnt = 0; req_hi = 0; max_out = 0;
        ack_addr.delete();
    endtask

    task automatic pulse_start(input logic [29:0] a, input int len);
        start_addr = a;
        frame_len  = LEN_W'(len);
        start      = 1'b1;
        tick(1);
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int k = 0;
        while (done_cnt == 0 && k < bound) begin tick(1); k++; end
        check({tag, "_done_seen"}, done_cnt > 0, 1'b1);
    endtask

    task automatic check_frame(input string tag, input logic [28:0] first, input int len);
        logic [28:0] ea = first;
        check({tag, "_done_count"}, done_cnt, len == 0 ? 0 : 1);
        check({tag, "_acks"}, ack_cnt, len);
        check({tag, "_beats"}, beat_cnt, len);
        check({tag, "_sb_empty"}, sb.size(), 0);
        check({tag, "_busy_after"}, busy, 1'b0);
        check({tag, "_overflow"}, overflow, 1'b0);
        for (int i = 0; i < ack_addr.size(); i++) begin
            check({tag, "_rd_addr"}, ack_addr[i], ea);
            ea = ea + 29'd8;
        end
    endtask

    typedef struct {
        logic [29:0] addr; int len; int ack_dly; int data_dly;
        logic [28:0] first; int max_out;
    } vec_t;
    vec_t vecs[4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{30'h0000_1000, 4,  2, 3, 29'h0000_0800, 0};
        vecs[1] = '{30'h3FFF_FFF0, 3,  1, 1, 29'h1FFF_FFF8, 0};  // address wrap
        vecs[2] = '{30'h0000_0203, 1,  3, 5, 29'h0000_0101, 0};  // odd byte addr
        vecs[3] = '{30'h0000_2000, 12, 1, 2, 29'h0000_1000, 1};  // ack+data same cycle

        // reset state
        tick(3);
        check("rst_busy", busy, 1'b0);
        check("rst_done", frame_read_done, 1'b0);
        check("rst_req", bus.mem_rd_req, 1'b0);
        check("rst_addr", bus.mem_rd_addr, 29'h0);
        check("rst_wr_en", bus.ofifo_wr_en, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        mem_reset = 1'b0;
        tick(2);

        // table-driven frames
        for (int v = 0; v < 4; v++) begin
            clear_counts();
            ack_dly  = vecs[v].ack_dly;
            data_dly = vecs[v].data_dly;
            pulse_start(vecs[v].addr, vecs[v].len);
            check("vec_busy", busy, 1'b1);
            wait_done("vec", 2000);
            tick(3);
            check_frame("vec", vecs[v].first, vecs[v].len);
            if (vecs[v].max_out > 0) check("vec_max_outstanding", max_out, vecs[v].max_out);
        end

        // zero-length frame
        clear_counts();
        pulse_start(30'h0000_4000, 0);
        check("len0_done_early", frame_read_done, 1'b0);
        check("len0_busy", busy, 1'b1);
        tick(1);
        check("len0_done", frame_read_done, 1'b1);
        check("len0_busy_clr", busy, 1'b0);
        tick(1);
        check("len0_done_pulse", frame_read_done, 1'b0);
        check("len0_no_req", req_hi, 0);

        // credit exhaustion with data withheld
        clear_counts();
        hold = 1; ack_dly = 1; data_dly = 1;
        pulse_start(30'h0000_8000, 20);
        tick(60);
        check("credit_acks", ack_cnt, 8);
        check("credit_req_low", bus.mem_rd_req, 1'b0);
        check("credit_no_beats", beat_cnt, 0);
        check("credit_busy", busy, 1'b1);
        hold = 0;
        wait_done("credit", 2000);
        tick(3);
        check_frame("credit", 29'h0000_4000, 20);

        // FIFO back-pressure after 3 bursts
        clear_counts();
        ack_dly = 1; data_dly = 2; pf_after = 3;
        pulse_start(30'h0000_C000, 20);
        tick(40);
        check("pf_acks", ack_cnt, 3);
        check("pf_req_low", bus.mem_rd_req, 1'b0);
        pf_after = -1;
        bus.ofifo_prog_full = 1'b0;
        wait_done("pf", 2000);
        tick(3);
        check_frame("pf", 29'h0000_6000, 20);

        // spurious beat while idle
        clear_counts();
        spur = 1;
        tick(3);
        check("spur_overflow", overflow, 1'b1);
        check("spur_beat", beat_cnt, 1);
        check("spur_busy", busy, 1'b0);

        // reset mid-frame, then a fresh frame
        clear_counts();
        ack_dly = 1; data_dly = 2;
        pulse_start(30'h0001_0000, 10);
        for (int k = 0; k < 500 && ack_cnt < 5; k++) tick(1);
        check("midrst_acks", ack_cnt, 5);
        mem_reset = 1'b1;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_req", bus.mem_rd_req, 1'b0);
        check("midrst_addr", bus.mem_rd_addr, 29'h0);
        check("midrst_wr_en", bus.ofifo_wr_en, 1'b0);
        check("midrst_done", frame_read_done, 1'b0);
        check("midrst_overflow", overflow, 1'b0);
        rq.delete(); sb.delete(); req_cnt = 0;
        tick(3);
        mem_reset = 1'b0;
        tick(3);
        check("midrst_no_done", done_cnt, 0);
        clear_counts();
        pulse_start(30'h0002_0000, 10);
        wait_done("fresh", 2000);
        tick(3);
        check_frame("fresh", 29'h0001_0000, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
